sign_extend_16to32: RTL and testbench

Immediate-field extender for the ID stage of the MIPS pipeline. It widens a 16-bit instruction immediate to 32 bits in one of four modes:
- sign-extend
- zero-extend
- upper (LUI)
- sign-extend shifted left 2 (branch offset)

It provides a combinational result for same-cycle use in decode, plus a registered copy with a valid flag for the ID/EX boundary.

---
 rtl/sign_extend_16to32.sv | 67 ++++++
 tb/tb_sign_extend_16to32.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sign_extend_16to32.sv
// rtl/sign_extend_16to32.sv - ID-stage immediate extender (sign/zero/upper/branch) with registered copy
// Optional SIGN_EXTEND_NEG_COUNT_EN adds a saturating count of loaded negative immediates.
module sign_extend_16to32 #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  immediate,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] extendedImmediate,
  output logic [OUT_WIDTH-1:0] ext_q,
  output logic                 ext_q_valid,
`ifdef SIGN_EXTEND_NEG_COUNT_EN
  output logic [CNT_WIDTH-1:0] neg_count,
`endif
  output logic                 is_negative
);

  localparam int PAD = OUT_WIDTH - IN_WIDTH;

  logic [OUT_WIDTH-1:0] sext;
  logic                 load;

  assign is_negative = immediate[IN_WIDTH-1];
  assign sext        = {{PAD{immediate[IN_WIDTH-1]}}, immediate};
  assign load        = !flush && !stall;

  // Unknown or 00 mode falls through to plain sign extension.
  always_comb begin
    extendedImmediate = sext;
    case (mode)
      2'b01:   extendedImmediate = {{PAD{1'b0}}, immediate};
      2'b10:   extendedImmediate = {immediate, {PAD{1'b0}}};
      2'b11:   extendedImmediate = {sext[OUT_WIDTH-3:0], 2'b00};
      default: extendedImmediate = sext;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q       <= '0;
      ext_q_valid <= 1'b0;
    end else if (flush) begin
      ext_q       <= '0;
      ext_q_valid <= 1'b0;
    end else if (!stall) begin
      ext_q       <= extendedImmediate;
      ext_q_valid <= in_valid;
    end
  end

`ifdef SIGN_EXTEND_NEG_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_count <= '0;
    end else if (load && in_valid && immediate[IN_WIDTH-1] && (neg_count != {CNT_WIDTH{1'b1}})) begin
      neg_count <= neg_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sign_extend_16to32.sv
// tb/tb_sign_extend_16to32.sv - self-checking bench for sign_extend_16to32 against an arithmetic model
module tb_sign_extend_16to32;

  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n;
  logic [15:0] immediate;
  logic [1:0]  mode;
  logic        in_valid, stall, flush;
  logic [31:0] extendedImmediate, ext_q;
  logic        ext_q_valid, is_negative;
`ifdef SIGN_EXTEND_NEG_COUNT_EN
  logic [CNT_W-1:0] neg_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] m_q;
  logic        m_v;
  int          m_cnt;

  sign_extend_16to32 #(.IN_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .immediate(immediate),
    .mode(mode),
    .in_valid(in_valid),
    .stall(stall),
    .flush(flush),
    .extendedImmediate(extendedImmediate),
    .ext_q(ext_q),
    .ext_q_valid(ext_q_valid),
`ifdef SIGN_EXTEND_NEG_COUNT_EN
    .neg_count(neg_count),
`endif
    .is_negative(is_negative)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: immediate interpreted as a signed/unsigned number, then scaled.
  function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] m);
    int s;
    s = int'($signed(imm));
    case (m)
      2'd1:    return 32'(imm);
      2'd2:    return 32'(imm) * 32'd65536;
      2'd3:    return 32'(s * 4);
      default: return 32'(s);
    endcase
  endfunction

  task automatic check_comb(input string tag);
    chk({tag, "_ext"}, extendedImmediate, model_ext(immediate, mode));
    chk({tag, "_neg"}, 32'(is_negative), 32'(immediate >= 16'h8000));
  endtask

  task automatic drive(input logic [15:0] imm, input logic [1:0] m, input logic v,
                       input logic s, input logic f);
    @(negedge clk);
    immediate = imm; mode = m; in_valid = v; stall = s; flush = f;
    #1 check_comb("cyc");
  endtask

  // Registered-path model and per-edge compare.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = '0; m_v = 1'b0; m_cnt = 0;
    end else if (flush) begin
      m_q = '0; m_v = 1'b0;
    end else if (!stall) begin
      m_q = model_ext(immediate, mode);
      m_v = in_valid;
      if (in_valid && immediate[15] && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    end
    #1;
    chk("reg_q", ext_q, m_q);
    chk("reg_v", 32'(ext_q_valid), 32'(m_v));
`ifdef SIGN_EXTEND_NEG_COUNT_EN
    chk("reg_cnt", 32'(neg_count), 32'(m_cnt));
`endif
  end

  logic [15:0] t_imm [13] = '{16'h0000, 16'h8001, 16'd69, 16'd1, 16'd100,
                              16'h8001, 16'h8001, 16'h8001, 16'h7FFF, 16'h8000,
                              16'hFFFF, 16'hFFFF, 16'h8000};
  logic [1:0]  t_mode[13] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                              2'd1, 2'd2, 2'd3, 2'd0, 2'd0,
                              2'd1, 2'd3, 2'd3};
  logic [31:0] t_exp [13] = '{32'h00000000, 32'hFFFF8001, 32'h00000045, 32'h00000001, 32'h00000064,
                              32'h00008001, 32'h80010000, 32'hFFFE0004, 32'h00007FFF, 32'hFFFF8000,
                              32'h0000FFFF, 32'hFFFFFFFC, 32'hFFFE0000};

  initial begin
    rst_n = 1'b0;
    immediate = '0; mode = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    // Hand-computed table, no clock running.
    for (int i = 0; i < 13; i++) begin
      immediate = t_imm[i]; mode = t_mode[i];
      #1;
      chk("lit_ext", extendedImmediate, t_exp[i]);
      chk("lit_model", model_ext(t_imm[i], t_mode[i]), t_exp[i]);
      if (t_imm[i] == 16'h8001) chk("lit_neg", 32'(is_negative), 32'd1);
    end
    chk("rst_q", ext_q, 32'd0);
    chk("rst_v", 32'(ext_q_valid), 32'd0);

    clk_en = 1'b1;
    @(negedge clk); rst_n = 1'b1;

    drive(16'h1234, 2'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("t3_q", ext_q, 32'h00001234);
    chk("t3_v", 32'(ext_q_valid), 32'd1);
    drive(16'hFFFF, 2'd0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("t3_stall_q", ext_q, 32'h00001234);
    drive(16'hFFFF, 2'd0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #2;
    chk("t4_q", ext_q, 32'd0);
    chk("t4_v", 32'(ext_q_valid), 32'd0);

    drive(16'h4321, 2'd1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t5_q", ext_q, 32'd0);
    chk("t5_v", 32'(ext_q_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;

`ifdef SIGN_EXTEND_NEG_COUNT_EN
    for (int i = 0; i < 5; i++) drive(16'h8000, 2'd0, 1'b1, 1'b0, 1'b0);
    drive(16'h8000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("t6_cnt", 32'(neg_count), 32'd3);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
`endif

    for (int i = 0; i < 400; i++) begin
      drive(16'($urandom), 2'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      if (i == 200) begin
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
    end
    @(posedge clk); #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
